pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and fetch stage of the single-cycle MIPS core. It sits directly upstream of `instruction_memory`: it owns the PC register and drives `instruction_memory.pc`. It takes back `instruction_memory.data` and presents the fetched word to the decoder. It resolves next-PC selection (sequential, branch, jump, jump-register), supports stall, and traps halt (BREAK) and fetch faults.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `IMEM_WORDS`, default 64: number of words in instruction memory. Valid PC range is 0 .. 4*IMEM_WORDS-4.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: when 1, hold PC and all state.
- `branch_taken` in 1: take the conditional branch this cycle.
- `branch_offset` in 32: sign-extended 16-bit immediate, in words.
- `jump` in 1: J/JAL this cycle.
- `jump_index` in 26: instr[25:0] of the jump.
- `jump_reg` in 1: JR/JALR this cycle.
- `jump_reg_addr` in 32: rs register value.
- `imem_data` in 32: connects to `instruction_memory.data`.
- `pc` out 32: current PC. Connects to `instruction_memory.pc`.
- `instr` out 32: instruction to the decoder.
- `pc_plus4` out 32: pc+4, used as the link value.
- `halted` out 1: 1 while in HALT.
- `fault` out 1: 1 while in FAULT.
- `fetch_count` out 32: count of instructions fetched.

## Operation
The block is a state machine with three states: RUN, HALT and FAULT.

**RUN**
- `instr` = `imem_data`, combinational pass-through.
- Next-PC candidates:
  - seq = pc+4
  - br = pc_plus4 + (branch_offset<<2)
  - j = {pc_plus4[31:28], jump_index, 2'b00}
  - jr = jump_reg_addr
- Selection priority: `jump_reg` > `jump` > `branch_taken` > seq. Multiple asserted requests are legal and resolved by this priority.
- All additions are 32-bit, modulo 2^32.
- When `stall`=1, all redirect requests are ignored that cycle. The decoder holds its instruction, so the same request reappears next cycle.

**Transitions out of RUN** (evaluated only when `stall`=0):
- `instr` is BREAK (opcode 6'h00, funct 6'h0D) → HALT. PC stays at the BREAK address.
- Otherwise, if the selected next PC has bits[1:0]≠0 or is ≥ 4*IMEM_WORDS → FAULT. PC stays at the current value and the offending target is not loaded.
- Otherwise PC ← selected next PC.
- BREAK detection takes precedence over fault detection.

**HALT and FAULT**
- Both are absorbing; only `reset` exits them.
- `instr` is forced to NOP (32'h0000_0000).
- PC is frozen. All inputs, including `stall`, are ignored.

**fetch_count**
- Increments by 1 on every RUN cycle with `stall`=0, including the cycle that fetches a BREAK.
- Saturates at 32'hFFFF_FFFF.

## Timing
- Reset (asynchronous assert, outputs valid immediately):
  - `pc`=RESET_VECTOR, `pc_plus4`=RESET_VECTOR+4, state=RUN, `fetch_count`=0, `halted`=0, `fault`=0.
  - `instr` = `imem_data` at RESET_VECTOR.
- Reset mid-operation (any state, any stall) aborts immediately to the values above.
- Redirect latency: a request asserted in cycle N takes effect at the edge ending cycle N. The target appears on `pc` in cycle N+1. There are no delay slots.
- `instr`, `pc_plus4` and `halted`/`fault` are functions of registered state plus combinational imem read. There are no extra pipeline registers.
- The BREAK word is visible on `instr` for exactly one unstalled cycle. `halted` rises at the following edge.
- `fault` rises at the edge following the bad selection.
- At the last word of memory (pc = 4*IMEM_WORDS-4), a sequential step faults.
- Wrap-around past 32'hFFFF_FFFC is a fault via the range check, not a silent wrap.

## Structure
- Shared package `mips_pkg` holds:
  - state enum {RUN, HALT, FAULT}
  - `NOP` = 32'h0
  - `OP_SPECIAL` = 6'h00
  - `FUNCT_BREAK` = 6'h0D
  - opcode/funct field slice constants
- Natural sub-module `npc_select`: combinational computation of seq/br/j/jr, the priority mux, and alignment/range check. It outputs `next_pc` and `next_bad`.
- `pc_fetch_unit` holds the PC register, state register and counter.

## Test plan
- **Reset and sequential fetch:** reset with RESET_VECTOR=0, then 5 unstalled cycles. Required: `pc` = 0,4,8,12,16; `fetch_count`=5; `instr` matches imem words 0..4.
- **Branch:** at pc=0x10 assert `branch_taken` with offset 32'hFFFF_FFFD (-3). Required: next pc = 0x14-12 = 0x08.
- **Jump vs branch priority:** same cycle, `jump_index`=26'h000000A and `branch_taken`=1. Required: next pc=0x28. With `jump_reg` also asserted and `jump_reg_addr`=0x3C, required: next pc=0x3C.
- **Stall:** 3 stall cycles at pc=0x08 with `jump`=1. Required: pc stays 0x08 and `fetch_count` unchanged. On release, pc = jump target.
- **Fault:** `jump_reg_addr`=0x0000_0006 (misaligned). Required: `fault`=1, pc unchanged, `instr`=0. Sequential step from 0xFC with IMEM_WORDS=64 also faults.
- **Halt:** BREAK (32'h0000_000D) stored at 0x0C. Required: `halted`=1 from the cycle after, pc=0x0C, `instr`=0, `fetch_count`=4. Asynchronous reset then clears it to pc=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
// Holds the fetch state encoding and instruction field helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam logic [5:0]  OP_SPECIAL  = 6'h00;
    localparam logic [5:0]  FUNCT_BREAK = 6'h0D;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    function automatic logic is_break(input logic [31:0] w);
        return (w[OP_MSB:OP_LSB] == OP_SPECIAL) &&
               (w[FUNCT_MSB:FUNCT_LSB] == FUNCT_BREAK);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_select.sv
// Next-PC candidate generation, priority select and target check.
// Purely combinational; the fetch unit decides whether to commit.
module npc_select #(
    parameter int IMEM_WORDS = 64
) (
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_addr,
    output logic [31:0] next_pc,
    output logic        next_bad
);

    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign br_tgt = pc_plus4 + {branch_offset[29:0], 2'b00};
    assign j_tgt  = {pc_plus4[31:28], jump_index, 2'b00};

    // Register jump wins over jump, which wins over branch.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = jump_reg_addr;
        end else if (jump) begin
            next_pc = j_tgt;
        end else if (branch_taken) begin
            next_pc = br_tgt;
        end
    end

    // Misaligned or out-of-memory targets are never loaded.
    always_comb begin
        next_bad = (next_pc[1:0] != 2'b00) || (next_pc >= PC_LIMIT);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch state machine and fetch counter.
// Instruction memory is read combinationally from the registered PC.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_WORDS   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  next_pc;
    logic         next_bad;

    assign pc_plus4 = pc_q + 32'd4;

    npc_select #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_npc (
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jump_reg_addr(jump_reg_addr),
        .next_pc      (next_pc),
        .next_bad     (next_bad)
    );

    // Next state, PC and count; BREAK outranks a bad target.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr   = NOP;
        unique case (state_q)
            RUN: begin
                instr = imem_data;
                if (!stall) begin
                    if (cnt_q != 32'hFFFF_FFFF) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    if (is_break(imem_data)) begin
                        state_d = HALT;
                    end else if (next_bad) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            HALT, FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // State registers with asynchronous reset to the boot vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit.
// Directed scenarios plus randomized redirects against a reference model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];

    int n_chk;
    int n_err;
    bit chk_en;

    // Reference model: 0 = running, 1 = halted, 2 = faulted
    logic [31:0] m_pc;
    int          m_st;
    logic [31:0] m_cnt;

    pc_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .IMEM_WORDS  (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jump_reg_addr(jump_reg_addr),
        .imem_data    (imem_data),
        .pc           (pc),
        .instr        (instr),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .fault        (fault),
        .fetch_count  (fetch_count)
    );

    assign imem_data = (pc < 32'd256) ? mem[pc[7:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ck(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: what the architecture says happens at each edge.
    always @(posedge clk or posedge reset) begin
        logic [31:0] w;
        logic [31:0] tgt;
        if (reset) begin
            m_pc  <= 32'h0;
            m_st  <= 0;
            m_cnt <= 32'h0;
        end else if (m_st == 0 && !stall) begin
            w = mem[m_pc[7:2]];
            if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
            if (jump_reg)
                tgt = jump_reg_addr;
            else if (jump)
                tgt = {m_pc[31:28], jump_index, 2'b00};
            else if (branch_taken)
                tgt = m_pc + 4 + branch_offset * 4;
            else
                tgt = m_pc + 4;
            if (w[31:26] == 6'd0 && w[5:0] == 6'd13)
                m_st <= 1;
            else if (tgt % 4 != 0 || tgt >= 256)
                m_st <= 2;
            else
                m_pc <= tgt;
        end
    end

    // Compare DUT outputs to the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            ck("pc", pc, m_pc);
            ck("pc_plus4", pc_plus4, m_pc + 32'd4);
            ck("instr", instr, (m_st == 0) ? mem[m_pc[7:2]] : 32'h0);
            ck("halted", {31'd0, halted}, (m_st == 1) ? 32'd1 : 32'd0);
            ck("fault", {31'd0, fault}, (m_st == 2) ? 32'd1 : 32'd0);
            ck("fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic cyc(input logic st, input logic br,
                       input logic [31:0] off, input logic j,
                       input logic [25:0] ji, input logic jr,
                       input logic [31:0] jra);
        stall         = st;
        branch_taken  = br;
        branch_offset = off;
        jump          = j;
        jump_index    = ji;
        jump_reg      = jr;
        jump_reg_addr = jra;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic lit(input string nm, input logic [31:0] d,
                       input logic [31:0] m, input logic [31:0] exp);
        ck({nm, "_dut"}, d, exp);
        ck({nm, "_model"}, m, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        reset  = 1'b0;
        stall = 0; branch_taken = 0; branch_offset = 0;
        jump = 0; jump_index = 0; jump_reg = 0; jump_reg_addr = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;

        // Reset, then sequential fetch and branch
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk);
        #2;
        lit("rst_pc", pc, m_pc, 32'h0);
        lit("rst_cnt", fetch_count, m_cnt, 32'h0);
        ck("rst_instr", instr, 32'h2000_0000);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idle();
            lit("seq_pc", pc, m_pc, 32'(4 * i));
        end
        cyc(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 26'h0, 1'b0, 32'h0);
        lit("br_pc", pc, m_pc, 32'h08);
        lit("br_cnt", fetch_count, m_cnt, 32'd5);

        // Stall holds a pending jump
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1, 26'hA, 1'b0, 32'h0);
            lit("stall_pc", pc, m_pc, 32'h08);
            lit("stall_cnt", fetch_count, m_cnt, 32'd5);
        end
        cyc(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1, 26'hA, 1'b0, 32'h0);
        lit("jmp_pc", pc, m_pc, 32'h28);
        cyc(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1, 26'hA, 1'b1, 32'h3C);
        lit("jr_pc", pc, m_pc, 32'h3C);

        // Misaligned register jump faults
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h6);
        ck("mis_fault", {31'd0, fault}, 32'd1);
        lit("mis_pc", pc, m_pc, 32'h3C);
        ck("mis_instr", instr, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 26'h1, 1'b0, 32'h0);
        ck("fault_hold", pc, 32'h3C);

        // Sequential step off the end of memory
        do_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFC);
        lit("last_pc", pc, m_pc, 32'hFC);
        idle();
        ck("end_fault", {31'd0, fault}, 32'd1);
        ck("end_pc", pc, 32'hFC);

        // BREAK at 0x0C halts
        mem[3] = 32'h0000_000D;
        do_reset();
        for (int i = 0; i < 3; i++) idle();
        ck("brk_seen", instr, 32'h0000_000D);
        idle();
        ck("halted", {31'd0, halted}, 32'd1);
        lit("halt_pc", pc, m_pc, 32'h0C);
        ck("halt_instr", instr, 32'h0);
        lit("halt_cnt", fetch_count, m_cnt, 32'd4);
        cyc(1'b1, 1'b1, 32'h4, 1'b1, 26'h2, 1'b1, 32'h20);
        ck("halt_hold", pc, 32'h0C);
        reset = 1'b1;
        #1;
        ck("arst_pc", pc, 32'h0);
        ck("arst_halt", {31'd0, halted}, 32'd0);
        ck("arst_instr", instr, 32'h2000_0000);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Randomized redirects against the model
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[40] = 32'h0000_000D;
        mem[57] = 32'h0000_1F4D;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (m_st != 0 && $urandom_range(0, 2) == 0) begin
                do_reset();
            end else begin
                logic [31:0] jra;
                jra = 32'($urandom_range(0, 70)) * 4;
                if ($urandom_range(0, 15) == 0) jra = jra | 32'($urandom_range(1, 3));
                cyc($urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0,
                    32'($signed($urandom_range(0, 40)) - 20),
                    $urandom_range(0, 5) == 0,
                    26'($urandom_range(0, 70)),
                    $urandom_range(0, 7) == 0,
                    jra);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
